npu_pe_sched: RTL and testbench

Scheduler for one chain of NPU processing engines (PEs) evaluating one neuron layer.
- Loads up to NUM_PE 16-bit inputs into the PEs' stored-data registers over a shared bus with per-PE write enables.
- Issues one weight-memory word per neuron (NUM_PE packed 16-bit weights) and gates the chain enable.
- Tags each accumulated result with its neuron index for the sigmoid unit.
- Sits between the NPU config/input FIFO and the PE chain plus weight RAM.

---
 rtl/npu_pe_sched.sv | 155 +++++++++++++++
 tb/tb_npu_pe_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_pe_sched.sv
// npu_pe_sched: input loader, weight issue and result tagging for one PE chain.
// Optional busy-cycle counter on perf_cycles when NPU_SCHED_PERF_EN is defined.
module npu_pe_sched #(
   parameter int NUM_PE     = 8,
   parameter int RESULT_LAT = 4,
   parameter int ADDR_W     = 10,
   parameter int NIDX_W     = 8
) (
   input  logic              CLK,
   input  logic              npu_rst,
   input  logic              cfg_start,
   input  logic [4:0]        cfg_num_inputs,
   input  logic [NIDX_W-1:0] cfg_num_neurons,
   input  logic [ADDR_W-1:0] cfg_wbase,
   input  logic              in_valid,
   input  logic [15:0]       in_data,
   output logic              in_ready,
   output logic [15:0]       pe_data_out,
   output logic [NUM_PE-1:0] pe_wren,
   output logic              pe_en,
   output logic              weight_rd_en,
   output logic [ADDR_W-1:0] weight_rd_addr,
   output logic              acc_valid,
   output logic [NIDX_W-1:0] acc_neuron,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       perf_cycles
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE
   } state_t;

   localparam logic [RESULT_LAT-1:0] TAIL =
      RESULT_LAT'(1) << (RESULT_LAT - 1);

   state_t              r_state;
   state_t              w_next;
   logic [4:0]          r_num_inputs;
   logic [4:0]          r_load_cnt;
   logic [NIDX_W-1:0]   r_num_neurons;
   logic [NIDX_W-1:0]   r_neuron_cnt;
   logic [ADDR_W-1:0]   r_wbase;
   logic                r_err;
   logic [RESULT_LAT-1:0] r_vld;
   logic [NIDX_W-1:0]   r_idx [RESULT_LAT];
   logic                w_start;
   logic                w_bad;
   logic                w_hs;
   logic                w_last_in;
   logic                w_last_nrn;
   logic                w_drained;

   assign w_start    = (r_state == S_IDLE) && cfg_start;
   assign w_bad      = (cfg_num_inputs == 5'd0)
                    || (cfg_num_inputs > 5'(NUM_PE))
                    || (cfg_num_neurons == '0);
   assign w_hs       = (r_state == S_LOAD) && in_valid;
   assign w_last_in  = w_hs && (r_load_cnt == r_num_inputs - 5'd1);
   assign w_last_nrn = r_neuron_cnt == r_num_neurons - NIDX_W'(1);
   // Issue is gap-free, so once only the tail is set it is the last result.
   assign w_drained  = r_vld == TAIL;

   assign in_ready     = r_state == S_LOAD;
   assign weight_rd_en = r_state == S_COMPUTE;
   assign pe_en        = (r_state == S_LOAD) || (r_state == S_COMPUTE)
                      || (r_state == S_DRAIN);
   assign busy         = r_state != S_IDLE;
   assign done         = r_state == S_DONE;
   assign err          = r_err;
   assign acc_valid    = r_vld[RESULT_LAT-1];
   assign acc_neuron   = r_idx[RESULT_LAT-1];

   always_comb begin
      w_next         = r_state;
      pe_data_out    = '0;
      pe_wren        = '0;
      weight_rd_addr = '0;
      unique case (r_state)
         S_IDLE: begin
            if (cfg_start) w_next = w_bad ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            if (w_hs) begin
               pe_data_out = in_data;
               pe_wren     = NUM_PE'(1) << r_load_cnt;
            end
            if (w_last_in) w_next = S_COMPUTE;
         end
         S_COMPUTE: begin
            weight_rd_addr = r_wbase + ADDR_W'(r_neuron_cnt);
            if (w_last_nrn) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_drained) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (npu_rst) begin
         r_state       <= S_IDLE;
         r_num_inputs  <= '0;
         r_num_neurons <= '0;
         r_wbase       <= '0;
         r_load_cnt    <= '0;
         r_neuron_cnt  <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_num_inputs  <= cfg_num_inputs;
            r_num_neurons <= cfg_num_neurons;
            r_wbase       <= cfg_wbase;
            r_load_cnt    <= '0;
            r_neuron_cnt  <= '0;
            r_err         <= w_bad;
         end
         if (w_hs) r_load_cnt <= r_load_cnt + 5'd1;
         if (r_state == S_COMPUTE)
            r_neuron_cnt <= r_neuron_cnt + NIDX_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (npu_rst) begin
         r_vld <= '0;
         for (int i = 0; i < RESULT_LAT; i++) r_idx[i] <= '0;
      end else begin
         r_vld[0] <= weight_rd_en;
         r_idx[0] <= r_neuron_cnt;
         for (int i = 1; i < RESULT_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_idx[i] <= r_idx[i-1];
         end
      end
   end

`ifdef NPU_SCHED_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge CLK) begin
      if (npu_rst || w_start) r_perf <= '0;
      else if (busy && (r_perf != 32'hFFFF_FFFF)) r_perf <= r_perf + 32'd1;
   end

   assign perf_cycles = r_perf;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_npu_pe_sched.sv
// tb_npu_pe_sched: cycle-timeline model of the layer schedule, checked every cycle.
// Directed layer/gap/error/wrap/reset cases followed by randomized layers.
module tb_npu_pe_sched;
   localparam int NUM_PE = 8;
   localparam int LAT    = 4;
   localparam int AW     = 10;
   localparam int NW     = 8;
   localparam int MAXC   = 6000;

   logic          CLK = 1'b0;
   logic          npu_rst, cfg_start, in_valid;
   logic [4:0]    cfg_num_inputs;
   logic [NW-1:0] cfg_num_neurons;
   logic [AW-1:0] cfg_wbase;
   logic [15:0]   in_data;
   logic          in_ready, pe_en, weight_rd_en, acc_valid;
   logic          busy, done, err;
   logic [15:0]   pe_data_out;
   logic [NUM_PE-1:0] pe_wren;
   logic [AW-1:0] weight_rd_addr;
   logic [NW-1:0] acc_neuron;
   logic [31:0]   perf_cycles;

   always #5 CLK = ~CLK;

   npu_pe_sched #(
      .NUM_PE(NUM_PE), .RESULT_LAT(LAT), .ADDR_W(AW), .NIDX_W(NW)
   ) dut (
      .CLK(CLK), .npu_rst(npu_rst), .cfg_start(cfg_start),
      .cfg_num_inputs(cfg_num_inputs), .cfg_num_neurons(cfg_num_neurons),
      .cfg_wbase(cfg_wbase), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .pe_data_out(pe_data_out), .pe_wren(pe_wren),
      .pe_en(pe_en), .weight_rd_en(weight_rd_en),
      .weight_rd_addr(weight_rd_addr), .acc_valid(acc_valid),
      .acc_neuron(acc_neuron), .busy(busy), .done(done), .err(err),
      .perf_cycles(perf_cycles)
   );

   typedef struct {
      logic [NUM_PE-1:0] wren;
      logic [15:0]       data;
      logic [AW-1:0]     addr;
      logic [NW-1:0]     nrn;
      logic rdy, pen, rd, acc, done, busy, err, st;
   } cyc_t;

   cyc_t    E [MAXC];
   cyc_t    O [MAXC];
   int      cyc = 0;
   int      nchk = 0;
   int      nerr = 0;
   int      cc;
   bit      chk_en = 0;
   longint  m_perf = 0;
   int      q_gaps[$];
   int      q_vals[$];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   // Expected timeline of one layer, written into E[] from the start cycle on.
   task automatic plan(input int s, input int ni, input int nn, input int wb,
                       output int cl, output int ed);
      bit bad;
      int t, c, g;
      bad = (ni == 0) || (ni > NUM_PE) || (nn == 0);
      E[s].st = 1'b1;
      for (int k = s + 1; k < MAXC; k++) E[k].err = bad;
      if (bad) begin
         E[s+1].busy = 1'b1;
         E[s+1].done = 1'b1;
         cl = s;
         ed = s + 1;
         return;
      end
      t  = s + 1;
      cl = s;
      for (int i = 0; i < ni; i++) begin
         g = (i < q_gaps.size()) ? q_gaps[i] : 0;
         repeat (g) begin
            E[t].rdy = 1'b1; E[t].pen = 1'b1; E[t].busy = 1'b1;
            t++;
         end
         E[t].rdy  = 1'b1; E[t].pen = 1'b1; E[t].busy = 1'b1;
         E[t].wren = NUM_PE'(1) << i;
         E[t].data = (i < q_vals.size()) ? 16'(q_vals[i]) : 16'($urandom);
         cl = t;
         t++;
      end
      for (int k = 0; k < nn; k++) begin
         c = cl + 1 + k;
         E[c].rd   = 1'b1;
         E[c].addr = AW'((wb + k) % (1 << AW));
         E[c].pen  = 1'b1;
         E[c].busy = 1'b1;
         E[c+LAT].acc = 1'b1;
         E[c+LAT].nrn = NW'(k);
      end
      for (int k = cl + nn + 1; k <= cl + nn + LAT; k++) begin
         E[k].pen  = 1'b1;
         E[k].busy = 1'b1;
      end
      ed = cl + nn + LAT + 1;
      E[ed].busy = 1'b1;
      E[ed].done = 1'b1;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input int noise);
      if (E[cyc].rdy) begin
         in_valid = E[cyc].wren != '0;
         in_data  = (E[cyc].wren != '0) ? E[cyc].data : 16'($urandom);
      end else begin
         in_valid = 1'($urandom);
         in_data  = 16'($urandom);
      end
      cfg_start = E[cyc].busy &&
                  (noise == 2 || (noise == 1 && $urandom_range(0, 2) == 0));
      if (cfg_start) begin
         cfg_num_inputs  = 5'($urandom_range(1, NUM_PE));
         cfg_num_neurons = NW'($urandom_range(1, 5));
         cfg_wbase       = AW'($urandom);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         drive(0);
      end
   endtask

   task automatic run_job(input int ni, input int nn, input int wb,
                          input int noise,
                          output int s, output int cl, output int ed);
      s = cyc;
      drive(0);
      cfg_start       = 1'b1;
      cfg_num_inputs  = 5'(ni);
      cfg_num_neurons = NW'(nn);
      cfg_wbase       = AW'(wb);
      plan(s, ni, nn, wb, cl, ed);
      while (cyc < ed) begin
         step();
         drive(noise);
      end
      @(negedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (chk_en) begin
         cc = cyc;
         O[cc].wren = pe_wren;
         O[cc].data = pe_data_out;
         O[cc].addr = weight_rd_addr;
         O[cc].nrn  = acc_neuron;
         O[cc].rdy  = in_ready;
         O[cc].pen  = pe_en;
         O[cc].rd   = weight_rd_en;
         O[cc].acc  = acc_valid;
         O[cc].done = done;
         O[cc].busy = busy;
         O[cc].err  = err;
         chk("pe_wren", pe_wren, E[cc].wren);
         if (E[cc].wren != '0) chk("pe_data_out", pe_data_out, E[cc].data);
         chk("in_ready", in_ready, E[cc].rdy);
         chk("pe_en", pe_en, E[cc].pen);
         chk("weight_rd_en", weight_rd_en, E[cc].rd);
         if (E[cc].rd) chk("weight_rd_addr", weight_rd_addr, E[cc].addr);
         chk("acc_valid", acc_valid, E[cc].acc);
         if (E[cc].acc) chk("acc_neuron", acc_neuron, E[cc].nrn);
         chk("done", done, E[cc].done);
         chk("busy", busy, E[cc].busy);
         chk("err", err, E[cc].err);
`ifdef NPU_SCHED_PERF_EN
         chk("perf_cycles", perf_cycles, m_perf);
`else
         chk("perf_cycles", perf_cycles, 0);
`endif
         if (npu_rst) m_perf = 0;
         else if (E[cc].st) m_perf = 0;
         else if (E[cc].busy && m_perf < 64'hFFFF_FFFF) m_perf++;
      end
   end

   initial begin
      int s, cl, ed, r, cnt, ni, nn;
      for (int c = 0; c < MAXC; c++) begin
         E[c] = '{default: 0};
         O[c] = '{default: 0};
      end
      npu_rst = 1'b1; cfg_start = 1'b0; in_valid = 1'b0; in_data = '0;
      cfg_num_inputs = '0; cfg_num_neurons = '0; cfg_wbase = '0;
      repeat (3) @(posedge CLK);
      #1;
      npu_rst = 1'b0;
      chk_en  = 1'b1;
      @(negedge CLK);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_wren", pe_wren, 0);
      chk("rst_addr", weight_rd_addr, 0);
      chk("rst_nrn", acc_neuron, 0);
      chk("rst_err", err, 0);
      chk("rst_perf", perf_cycles, 0);
      idle(1);

      // basic layer, with cfg_start hammered while busy
      q_gaps = '{}; q_vals = '{5, 6, 7};
      run_job(3, 2, 'h10, 2, s, cl, ed);
      chk("t1_wren0", O[s+1].wren, 1); chk("t1_data0", O[s+1].data, 5);
      chk("t1_wren1", O[s+2].wren, 2); chk("t1_data1", O[s+2].data, 6);
      chk("t1_wren2", O[s+3].wren, 4); chk("t1_data2", O[s+3].data, 7);
      chk("t1_addr0", O[s+4].addr, 'h10);
      chk("t1_addr1", O[s+5].addr, 'h11);
      chk("t1_rd_off", O[s+6].rd, 0);
      chk("t1_acc0", O[s+8].acc, 1); chk("t1_nrn0", O[s+8].nrn, 0);
      chk("t1_acc1", O[s+9].acc, 1); chk("t1_nrn1", O[s+9].nrn, 1);
      chk("t1_done", O[s+10].done, 1);
      chk("t1_nodone", O[s+9].done, 0);
      idle(1);
`ifdef NPU_SCHED_PERF_EN
      @(negedge CLK);
      #1;
      chk("t6_perf", perf_cycles, 10);
`endif

      // gapped input stream
      q_gaps = '{0, 1, 1}; q_vals = '{};
      run_job(3, 2, 'h20, 0, s, cl, ed);
      cnt = 0;
      for (int c = s; c <= ed; c++) cnt += (O[c].wren != '0) ? 1 : 0;
      chk("t2_writes", cnt, 3);
      chk("t2_gap", O[s+2].wren, 0);
      chk("t2_last", O[s+5].wren, 4);
      chk("t2_rd_pre", O[s+5].rd, 0);
      chk("t2_rd_go", O[s+6].rd, 1);
      idle(2);

      // bad configurations, then a good one clears err
      q_gaps = '{};
      run_job(0, 2, 0, 0, s, cl, ed);
      chk("t3a_err", O[s+1].err, 1); chk("t3a_done", O[s+1].done, 1);
      chk("t3a_rd", O[s+1].rd, 0);
      idle(2);
      run_job(NUM_PE + 1, 2, 0, 0, s, cl, ed);
      chk("t3b_err", O[s+1].err, 1); chk("t3b_done", O[s+1].done, 1);
      chk("t3b_wren", O[s+1].wren, 0);
      idle(2);
      run_job(2, 1, 5, 0, s, cl, ed);
      chk("t3c_clr", O[s+1].err, 0);
      idle(1);

      // address wrap
      run_job(1, 3, (1 << AW) - 1, 0, s, cl, ed);
      chk("t4_a0", O[s+2].addr, (1 << AW) - 1);
      chk("t4_a1", O[s+3].addr, 0);
      chk("t4_a2", O[s+4].addr, 1);
      chk("t4_n2", O[s+8].nrn, 2);
      idle(1);

      // reset while neuron 1 of 4 issues
      s = cyc;
      drive(0);
      cfg_start = 1'b1; cfg_num_inputs = 5'd2;
      cfg_num_neurons = NW'(4); cfg_wbase = AW'('h40);
      plan(s, 2, 4, 'h40, cl, ed);
      while (cyc < cl + 2) begin
         step();
         drive(0);
      end
      r = cyc;
      npu_rst = 1'b1;
      for (int c = r + 1; c < MAXC; c++) E[c] = '{default: 0};
      step();
      npu_rst = 1'b0;
      drive(0);
      idle(8);
      @(negedge CLK);
      #1;
      chk("t5_addr", O[r].addr, 'h41);
      chk("t5_busy", O[r+1].busy, 0);
      chk("t5_pen", O[r+1].pen, 0);
      cnt = 0;
      for (int c = r + 1; c <= r + 9; c++)
         cnt += (O[c].acc || O[c].done) ? 1 : 0;
      chk("t5_quiet", cnt, 0);

      for (int j = 0; j < 30; j++) begin
         ni = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NUM_PE + 2)
                                           : $urandom_range(1, NUM_PE);
         nn = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 6);
         q_gaps = '{};
         for (int i = 0; i < NUM_PE; i++) q_gaps.push_back($urandom_range(0, 2));
         run_job(ni, nn, $urandom_range(0, (1 << AW) - 1), 1, s, cl, ed);
         idle($urandom_range(1, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
